// File: rtl/fir_pkg.sv
// Shared FIR datapath definitions: FSM states, clog2 and saturation code helpers.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } fir_state_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Two's complement extreme codes for a w-bit signed output word.
  function automatic logic [63:0] sat_max_code(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min_code(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/fp_saturate.sv
// Combinational fixed-point narrowing: truncate (or round-half-up when
// FIR_ACC_ROUND_EN is defined), then clamp to the output integer range.
module fp_saturate
  import fir_pkg::*;
#(
  parameter int WI_IN  = 12,
  parameter int WF_IN  = 32,
  parameter int WI_OUT = 4,
  parameter int WF_OUT = 16
) (
  input  logic [WI_IN+WF_IN-1:0]   din,
  output logic [WI_OUT+WF_OUT-1:0] dout,
  output logic                     ovf
);

  localparam int WIN  = WI_IN + WF_IN;
  localparam int WOUT = WI_OUT + WF_OUT;
  localparam int SH   = WF_IN - WF_OUT;
  localparam int WT   = WIN - SH;
  localparam logic [WOUT-1:0] MAXC = WOUT'(sat_max_code(WOUT));
  localparam logic [WOUT-1:0] MINC = WOUT'(sat_min_code(WOUT));

  // One guard bit on top so the rounding increment can never wrap.
  logic [WIN:0] ext;
  logic [WT:0]  trunc;
  logic [WT-WOUT+1:0] hi;
  logic in_range;

`ifdef FIR_ACC_ROUND_EN
  generate
    if (SH > 0) begin : g_round
      assign ext = {din[WIN-1], din} + ((WIN+1)'(1) << (SH - 1));
    end else begin : g_noround
      assign ext = {din[WIN-1], din};
    end
  endgenerate
`else
  assign ext = {din[WIN-1], din};
`endif

  assign trunc = ext[WIN:SH];

  generate
    if (SH > 0) begin : g_frac
      logic unused_frac;
      assign unused_frac = ^ext[SH-1:0];
    end
  endgenerate

  // Value fits when every bit above the output sign bit matches it.
  assign hi       = trunc[WT:WOUT-1];
  assign in_range = (&hi) | ~(|hi);

  always_comb begin
    dout = trunc[WOUT-1:0];
    ovf  = 1'b0;
    if (!in_range) begin
      ovf  = 1'b1;
      dout = trunc[WT] ? MINC : MAXC;
    end
  end

endmodule

// File: rtl/fir_mac_accumulator.sv
// FIR accumulate stage: sums NTAPS tap products per sample and emits a
// saturated Q(WI_O).(WF_O) result. Build option: FIR_ACC_ROUND_EN (rounding).
module fir_mac_accumulator
  import fir_pkg::*;
#(
  parameter int WI_P  = 8,
  parameter int WF_P  = 32,
  parameter int NTAPS = 16,
  parameter int WI_O  = 4,
  parameter int WF_O  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 prod_valid,
  input  logic [WI_P+WF_P-1:0] prod,
  output logic [WI_O+WF_O-1:0] acc_out,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 ovf
);

  localparam int GB = clog2(NTAPS);
  localparam int WP = WI_P + WF_P;
  localparam int WA = WP + GB;
  localparam int CW = clog2(NTAPS);
  localparam logic [CW-1:0] LAST_TAP = CW'(NTAPS - 1);

  fir_state_t state, state_next;
  logic [WA-1:0] acc;
  logic [CW-1:0] tap_cnt;
  logic [WI_O+WF_O-1:0] sat_out;
  logic sat_ovf;

  fp_saturate #(
    .WI_IN (WI_P + GB),
    .WF_IN (WF_P),
    .WI_OUT(WI_O),
    .WF_OUT(WF_O)
  ) u_sat (
    .din (acc),
    .dout(sat_out),
    .ovf (sat_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = ACCUM;
      end
      ACCUM: begin
        busy = 1'b1;
        if (prod_valid && tap_cnt == LAST_TAP) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Guard bits make the running sum wide enough that it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      tap_cnt   <= '0;
      acc_out   <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc     <= '0;
            tap_cnt <= '0;
          end
        end
        ACCUM: begin
          if (prod_valid) begin
            acc     <= acc + {{GB{prod[WP-1]}}, prod};
            tap_cnt <= tap_cnt + 1'b1;
          end
        end
        DONE: begin
          acc_out   <= sat_out;
          ovf       <= sat_ovf;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
